// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between register-file control and the mult/div unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO registers
// Works on magnitudes for WIDTH steps, then a single FIX cycle applies signs and loads HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rstd,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, raw_a;

    assign in_sign_a = bus.op[0] & bus.operand_a[WIDTH-1];
    assign in_sign_b = bus.op[0] & bus.operand_b[WIDTH-1];
    assign abs_a     = in_sign_a ? -bus.operand_a : bus.operand_a;
    assign abs_b     = in_sign_b ? -bus.operand_b : bus.operand_b;

    // acc holds {partial product, remaining multiplier bits} for MUL and {remainder, quotient} for DIV.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

    assign prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign raw_a     = sign_a_q ? -a_q : a_q;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    a_d      = abs_a;
                    b_d      = abs_b;
                    acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    is_div_d = bus.op[1];
                    cnt_d    = '0;
                    state_d  = bus.op[1] ? S_DIV : S_MUL;
                end else begin
                    if (bus.mthi) hi_d = bus.mt_data;
                    if (bus.mtlo) lo_d = bus.mt_data;
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_DIV: begin
                // Borrow out of the trial subtract means the divisor did not fit: shift in a 0.
                if (!div_trial[WIDTH]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = raw_a;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    logic clk;
    logic rstd;

    mult_div_unit_if #(.WIDTH(32)) ifc ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = {32'h0, a} * {32'h0, b};
            2'b01: res = sa * sb;
            2'b10: res = (b == 0) ? {a, 32'hffff_ffff} : {a % b, a / b};
            default: begin
                if (b == 0) res = {a, 32'hffff_ffff};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rstd && ifc.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_hi"}, {32'h0, ifc.hi}, {32'h0, e.hi});
                check({e.tag, "_lo"}, {32'h0, ifc.lo}, {32'h0, e.lo});
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int disturb_at, input int reset_at);
        exp_t        e;
        int          busy_cycles;
        int          late_done;
        bit          seen_done;
        logic [31:0] pre_hi, pre_lo;
        busy_cycles = 0;
        late_done   = 0;
        seen_done   = 1'b0;
        if (reset_at < 0) begin
            e.hi  = exp[63:32];
            e.lo  = exp[31:0];
            e.tag = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        pre_hi        = ifc.hi;
        pre_lo        = ifc.lo;
        ifc.start     = 1'b1;
        ifc.op        = op;
        ifc.operand_a = a;
        ifc.operand_b = b;
        @(negedge clk);
        ifc.start     = 1'b0;
        ifc.mthi      = 1'b0;
        ifc.mtlo      = 1'b0;
        ifc.operand_a = $urandom;
        ifc.operand_b = $urandom;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == disturb_at) begin
                ifc.start   = 1'b1;
                ifc.op      = ~op;
                ifc.mthi    = 1'b1;
                ifc.mtlo    = 1'b1;
                ifc.mt_data = 32'hdead_beef;
            end else if (cyc == disturb_at + 1) begin
                ifc.start = 1'b0;
                ifc.mthi  = 1'b0;
                ifc.mtlo  = 1'b0;
            end
            if (cyc == reset_at) begin
                rstd = 1'b0;
                #1;
                check({tag, "_rst_busy"}, {63'h0, ifc.busy}, 64'd0);
                check({tag, "_rst_done"}, {63'h0, ifc.done}, 64'd0);
                check({tag, "_rst_hilo"}, {ifc.hi, ifc.lo}, 64'd0);
                @(negedge clk);
                @(negedge clk);
                rstd = 1'b1;
                for (int k = 0; k < 45; k++) begin
                    @(negedge clk);
                    if (ifc.done) late_done++;
                end
                check({tag, "_no_done_after_rst"}, 64'(late_done), 64'd0);
                return;
            end
            if (cyc == 5) check({tag, "_hold_while_busy"}, {ifc.hi, ifc.lo}, {pre_hi, pre_lo});
            if (ifc.busy) busy_cycles++;
            if (ifc.done) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {63'h0, seen_done}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        @(negedge clk);
        check({tag, "_done_pulse"}, {62'h0, ifc.done, ifc.busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        rstd          = 1'b0;
        ifc.start     = 1'b0;
        ifc.op        = 2'b00;
        ifc.operand_a = '0;
        ifc.operand_b = '0;
        ifc.mthi      = 1'b0;
        ifc.mtlo      = 1'b0;
        ifc.mt_data   = '0;
        #1;
        check("reset_state", {60'h0, ifc.busy, ifc.done, |ifc.hi, |ifc.lo}, 64'd0);
        repeat (2) @(negedge clk);
        rstd = 1'b1;

        run_op("multu_max",  2'b00, 32'hffff_ffff, 32'hffff_ffff, 64'hffff_fffe_0000_0001, -1, -1);
        run_op("mult_m3x7",  2'b01, 32'hffff_fffd, 32'd7,         64'hffff_ffff_ffff_ffeb, -1, -1);
        run_op("mult_min2",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, -1);
        run_op("divu_7_2",   2'b10, 32'd7,         32'd2,         64'h0000_0001_0000_0003, -1, -1);
        run_op("div_m7_2",   2'b11, 32'hffff_fff9, 32'd2,         64'hffff_ffff_ffff_fffd, -1, -1);
        run_op("div_7_m2",   2'b11, 32'd7,         32'hffff_fffe, 64'h0000_0001_ffff_fffd, -1, -1);
        run_op("divu_5_0",   2'b10, 32'd5,         32'd0,         64'h0000_0005_ffff_ffff, -1, -1);
        run_op("div_m7_0",   2'b11, 32'hffff_fff9, 32'd0,         64'hffff_fff9_ffff_ffff, -1, -1);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000, -1, -1);

        run_op("multu_disturb", 2'b00, 32'd6, 32'd7, 64'h0000_0000_0000_002a, 10, -1);

        @(negedge clk);
        ifc.mtlo    = 1'b1;
        ifc.mt_data = 32'h0000_1234;
        @(negedge clk);
        ifc.mtlo    = 1'b0;
        check("mtlo_idle", {ifc.hi, ifc.lo}, 64'h0000_0000_0000_1234);
        ifc.mthi    = 1'b1;
        ifc.mtlo    = 1'b1;
        ifc.mt_data = 32'ha5a5_0001;
        @(negedge clk);
        ifc.mthi    = 1'b0;
        ifc.mtlo    = 1'b0;
        check("mthi_mtlo_both", {ifc.hi, ifc.lo}, 64'ha5a5_0001_a5a5_0001);

        ifc.mthi    = 1'b1;
        ifc.mtlo    = 1'b1;
        ifc.mt_data = 32'h5555_aaaa;
        run_op("start_beats_mt", 2'b00, 32'd2, 32'd3, 64'h0000_0000_0000_0006, -1, -1);

        run_op("div_reset",  2'b11, 32'hffff_ff9c, 32'd7, 64'h0, -1, 12);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000e, -1, -1);

        for (int i = 0; i < 8; i++) begin
            rop = 2'(i % 4);
            ra  = $urandom;
            rb  = (i == 6) ? 32'd0 : ((i == 3) ? 32'($urandom_range(1, 40)) : $urandom);
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), -1, -1);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
